// File: rtl/dcache_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data cache.
//   Requester side (per port N = 0,1):
//     mN_req, mN_we, mN_addr[31:0], mN_width[2:0], mN_sign, mN_wdata[31:0]
//     are driven by the requester. mN_gnt and mN_ack are returned to it.
//   m_rdata[31:0] : shared read data returned to whichever port is acked.
//   Cache side: c_en, c_ren, c_wen, c_addr, c_wdata, c_rwidth, c_wwidth,
//     c_rsign are driven to the cache. c_rdata and c_valid come back from it.
//   err_timeout : sticky stall-timeout flag.
// Modports: slave = arbiter view, master = environment (requesters + cache).
interface dcache_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [2:0]  m0_width;
  logic        m0_sign;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_ack;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [2:0]  m1_width;
  logic        m1_sign;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_ack;

  logic [31:0] m_rdata;

  logic        c_en;
  logic        c_ren;
  logic        c_wen;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_rwidth;
  logic [2:0]  c_wwidth;
  logic        c_rsign;
  logic [31:0] c_rdata;
  logic        c_valid;

  logic        err_timeout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_width, m0_sign, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_width, m1_sign, m1_wdata,
    input  c_rdata, c_valid,
    output m0_gnt, m0_ack, m1_gnt, m1_ack, m_rdata,
    output c_en, c_ren, c_wen, c_addr, c_wdata, c_rwidth, c_wwidth, c_rsign,
    output err_timeout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_width, m0_sign, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_width, m1_sign, m1_wdata,
    output c_rdata, c_valid,
    input  m0_gnt, m0_ack, m1_gnt, m1_ack, m_rdata,
    input  c_en, c_ren, c_wen, c_addr, c_wdata, c_rwidth, c_wwidth, c_rsign,
    input  err_timeout
  );
endinterface

// File: rtl/dcache_arbiter.sv
// Two-port arbiter/sequencer in front of a single data-cache port.
// Port 0 (load/store unit) and port 1 (debug/DMA) share the cache. A request
// is granted and issued combinationally in the cycle it is seen, then held
// stable on the cache bus while the cache reports not-valid. The completion
// is routed back to the port that issued it. A sticky flag reports a stall
// that lasts TIMEOUT cycles.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : dcache_arbiter_if.slave (requester handshakes + cache bus)
module dcache_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  dcache_arbiter_if.slave bus
);

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_last;
  logic        r_we;
  logic        r_sign;
  logic [2:0]  r_width;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_done;
  logic        w_held;
  logic        w_issue;
  logic        w_win;
  logic        w_act;
  logic        w_we;
  logic        w_sign;
  logic [2:0]  w_width;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [15:0] w_cnt_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_act       = 1'b0;
    w_we        = 1'b0;
    w_sign      = 1'b0;
    w_width     = 3'd0;
    w_addr      = 32'd0;
    w_wdata     = 32'd0;

    w_done  = rst && (r_state == S_WAIT) && bus.c_valid;
    w_held  = rst && (r_state == S_WAIT) && !bus.c_valid;
    // A completing transaction frees the cache in the same cycle, so WAIT
    // with c_valid=1 can issue exactly like IDLE.
    w_issue = rst && ((r_state == S_IDLE) || bus.c_valid) &&
              (bus.m0_req || bus.m1_req);
    // Round-robin on conflict: the port not granted last time wins.
    w_win   = (bus.m0_req && bus.m1_req) ? ~r_last : bus.m1_req;

    if (w_issue)
      w_state_nxt = S_WAIT;
    else if (w_done)
      w_state_nxt = S_IDLE;

    if (w_issue) begin
      w_act = 1'b1;
      if (w_win) begin
        w_we    = bus.m1_we;
        w_sign  = bus.m1_sign;
        w_width = bus.m1_width;
        w_addr  = bus.m1_addr;
        w_wdata = bus.m1_wdata;
      end else begin
        w_we    = bus.m0_we;
        w_sign  = bus.m0_sign;
        w_width = bus.m0_width;
        w_addr  = bus.m0_addr;
        w_wdata = bus.m0_wdata;
      end
    end else if (w_held) begin
      // Cache re-samples every stalled edge; replay the held request.
      w_act   = 1'b1;
      w_we    = r_we;
      w_sign  = r_sign;
      w_width = r_width;
      w_addr  = r_addr;
      w_wdata = r_wdata;
    end
  end

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  assign bus.c_en        = w_issue;
  assign bus.c_ren       = w_act & ~w_we;
  assign bus.c_wen       = w_act & w_we;
  assign bus.c_addr      = w_addr;
  assign bus.c_wdata     = w_wdata;
  assign bus.c_rwidth    = w_width;
  assign bus.c_wwidth    = w_width;
  assign bus.c_rsign     = w_sign;
  assign bus.m0_gnt      = w_issue & ~w_win;
  assign bus.m1_gnt      = w_issue & w_win;
  assign bus.m0_ack      = w_done & ~r_owner;
  assign bus.m1_ack      = w_done & r_owner;
  assign bus.m_rdata     = bus.c_rdata;
  assign bus.err_timeout = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_width <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_we    <= w_we;
        r_sign  <= w_sign;
        r_width <= w_width;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_cnt   <= 16'd0;
      end else if (w_held) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == TO_VAL)
          r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
module tb_dcache_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  dcache_arbiter_if bus_if ();

  dcache_arbiter #(.TIMEOUT(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b0;
    bus_if.m0_req = 0; bus_if.m0_we = 0; bus_if.m0_addr = 0; bus_if.m0_width = 0;
    bus_if.m0_sign = 0; bus_if.m0_wdata = 0;
    bus_if.m1_req = 0; bus_if.m1_we = 0; bus_if.m1_addr = 0; bus_if.m1_width = 0;
    bus_if.m1_sign = 0; bus_if.m1_wdata = 0;
    bus_if.c_valid = 1'b1;
    bus_if.c_rdata = 32'd0;

    // Outputs are forced quiet while reset is held, even with requests pending.
    #1;
    bus_if.m0_req = 1; bus_if.m1_req = 1; bus_if.m0_addr = 32'hABC;
    #2;
    chk("rst_m0_gnt", 32'(bus_if.m0_gnt), 0);
    chk("rst_m1_gnt", 32'(bus_if.m1_gnt), 0);
    chk("rst_c_en", 32'(bus_if.c_en), 0);
    chk("rst_c_addr", bus_if.c_addr, 0);
    chk("rst_err", 32'(bus_if.err_timeout), 0);
    bus_if.m0_req = 0; bus_if.m1_req = 0;
    cyc;
    rst = 1'b1;

    // Single read on port 0.
    bus_if.m0_req = 1; bus_if.m0_we = 0; bus_if.m0_addr = 32'h100; bus_if.m0_width = 3'd2;
    mid;
    chk("rd_gnt0", 32'(bus_if.m0_gnt), 1);
    chk("rd_c_en", 32'(bus_if.c_en), 1);
    chk("rd_c_ren", 32'(bus_if.c_ren), 1);
    chk("rd_c_wen", 32'(bus_if.c_wen), 0);
    chk("rd_c_addr", bus_if.c_addr, 32'h100);
    chk("rd_c_rwidth", 32'(bus_if.c_rwidth), 2);
    cyc;
    bus_if.m0_req = 0; bus_if.c_valid = 1; bus_if.c_rdata = 32'hDEADBEEF;
    mid;
    chk("rd_ack0", 32'(bus_if.m0_ack), 1);
    chk("rd_ack1", 32'(bus_if.m1_ack), 0);
    chk("rd_rdata", bus_if.m_rdata, 32'hDEADBEEF);
    chk("rd_c_en_after", 32'(bus_if.c_en), 0);
    cyc;

    // Stalled write on port 1; a port-0 request waits out the stall.
    bus_if.m1_req = 1; bus_if.m1_we = 1; bus_if.m1_addr = 32'h200;
    bus_if.m1_wdata = 32'h55; bus_if.m1_width = 3'd2;
    mid;
    chk("st_gnt1", 32'(bus_if.m1_gnt), 1);
    chk("st_gnt0", 32'(bus_if.m0_gnt), 0);
    chk("st_c_wen", 32'(bus_if.c_wen), 1);
    cyc;
    bus_if.m1_req = 0; bus_if.c_valid = 0;
    bus_if.m0_req = 1; bus_if.m0_we = 0; bus_if.m0_addr = 32'h300;
    for (int j = 1; j <= 3; j++) begin
      mid;
      chk($sformatf("st_c_addr_%0d", j), bus_if.c_addr, 32'h200);
      chk($sformatf("st_c_wdata_%0d", j), bus_if.c_wdata, 32'h55);
      chk($sformatf("st_c_wen_%0d", j), 32'(bus_if.c_wen), 1);
      chk($sformatf("st_c_en_%0d", j), 32'(bus_if.c_en), 0);
      chk($sformatf("st_nogrant_%0d", j), 32'(bus_if.m0_gnt), 0);
      chk($sformatf("st_noack_%0d", j), 32'(bus_if.m1_ack), 0);
      cyc;
    end
    bus_if.c_valid = 1;
    mid;
    chk("st_ack1", 32'(bus_if.m1_ack), 1);
    chk("st_next_gnt0", 32'(bus_if.m0_gnt), 1);
    chk("st_next_addr", bus_if.c_addr, 32'h300);
    chk("st_next_ren", 32'(bus_if.c_ren), 1);
    cyc;
    bus_if.m0_req = 0;
    mid;
    chk("st_ack0", 32'(bus_if.m0_ack), 1);
    chk("st_ack1_off", 32'(bus_if.m1_ack), 0);
    cyc;

    // Contention: last grant was port 0, so port 1 goes first.
    bus_if.m0_we = 0; bus_if.m0_addr = 32'h1000;
    bus_if.m1_we = 0; bus_if.m1_addr = 32'h2000;
    bus_if.m0_req = 1; bus_if.m1_req = 1;
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) begin bus_if.m0_req = 0; bus_if.m1_req = 0; end
      mid;
      if (k < 4) begin
        chk($sformatf("ct_gnt1_%0d", k), 32'(bus_if.m1_gnt), (k % 2 == 0) ? 1 : 0);
        chk($sformatf("ct_gnt0_%0d", k), 32'(bus_if.m0_gnt), (k % 2 == 1) ? 1 : 0);
        chk($sformatf("ct_addr_%0d", k), bus_if.c_addr, (k % 2 == 0) ? 32'h2000 : 32'h1000);
      end
      if (k > 0) begin
        chk($sformatf("ct_ack1_%0d", k), 32'(bus_if.m1_ack), ((k - 1) % 2 == 0) ? 1 : 0);
        chk($sformatf("ct_ack0_%0d", k), 32'(bus_if.m0_ack), ((k - 1) % 2 == 1) ? 1 : 0);
      end
      cyc;
    end

    // Back-to-back on port 0 with no stalls.
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        bus_if.m0_req = 1; bus_if.m0_addr = 32'h40 + 32'(4 * k);
      end else begin
        bus_if.m0_req = 0;
      end
      mid;
      chk($sformatf("bb_gnt0_%0d", k), 32'(bus_if.m0_gnt), (k < 4) ? 1 : 0);
      if (k < 4) chk($sformatf("bb_addr_%0d", k), bus_if.c_addr, 32'h40 + 32'(4 * k));
      if (k > 0) chk($sformatf("bb_ack0_%0d", k), 32'(bus_if.m0_ack), 1);
      cyc;
    end

    // Timeout: 8 stall cycles set the sticky flag.
    bus_if.m1_req = 1; bus_if.m1_we = 0; bus_if.m1_addr = 32'h500;
    mid;
    chk("to_gnt1", 32'(bus_if.m1_gnt), 1);
    cyc;
    bus_if.m1_req = 0; bus_if.c_valid = 0;
    for (int j = 1; j <= 10; j++) begin
      mid;
      if (j == 1) chk("to_err_s1", 32'(bus_if.err_timeout), 0);
      if (j == 8) chk("to_err_s8", 32'(bus_if.err_timeout), 0);
      if (j == 9) chk("to_err_s9", 32'(bus_if.err_timeout), 1);
      cyc;
    end
    bus_if.c_valid = 1;
    mid;
    chk("to_ack1", 32'(bus_if.m1_ack), 1);
    chk("to_err_ack", 32'(bus_if.err_timeout), 1);
    cyc;
    bus_if.m0_req = 1; bus_if.m0_addr = 32'h510;
    mid;
    chk("to_gnt0", 32'(bus_if.m0_gnt), 1);
    cyc;
    bus_if.m0_req = 0;
    mid;
    chk("to_ack0", 32'(bus_if.m0_ack), 1);
    chk("to_err_sticky", 32'(bus_if.err_timeout), 1);
    cyc;

    // Asynchronous reset in the middle of a held write.
    bus_if.m0_req = 1; bus_if.m0_we = 1; bus_if.m0_addr = 32'h600; bus_if.m0_wdata = 32'h77;
    mid;
    chk("ar_gnt0", 32'(bus_if.m0_gnt), 1);
    cyc;
    bus_if.m0_req = 0; bus_if.c_valid = 0;
    mid;
    chk("ar_held_wen", 32'(bus_if.c_wen), 1);
    cyc;
    #1;
    bus_if.c_valid = 1;
    #1;
    chk("ar_ack_pre", 32'(bus_if.m0_ack), 1);
    bus_if.m0_req = 1; bus_if.m1_req = 1;
    rst = 1'b0;
    #1;
    chk("ar_ack0", 32'(bus_if.m0_ack), 0);
    chk("ar_c_wen", 32'(bus_if.c_wen), 0);
    chk("ar_c_ren", 32'(bus_if.c_ren), 0);
    chk("ar_c_en", 32'(bus_if.c_en), 0);
    chk("ar_gnt0", 32'(bus_if.m0_gnt), 0);
    chk("ar_gnt1", 32'(bus_if.m1_gnt), 0);
    chk("ar_c_addr", bus_if.c_addr, 0);
    chk("ar_err_clr", 32'(bus_if.err_timeout), 0);
    cyc;
    cyc;
    bus_if.m0_we = 0; bus_if.m0_addr = 32'h700;
    bus_if.m1_we = 0; bus_if.m1_addr = 32'h800;
    rst = 1'b1;
    mid;
    chk("ar_first_gnt0", 32'(bus_if.m0_gnt), 1);
    chk("ar_first_gnt1", 32'(bus_if.m1_gnt), 0);
    chk("ar_no_stale_ack", 32'(bus_if.m0_ack), 0);
    chk("ar_first_addr", bus_if.c_addr, 32'h700);
    cyc;
    mid;
    chk("ar_second_gnt1", 32'(bus_if.m1_gnt), 1);
    chk("ar_second_ack0", 32'(bus_if.m0_ack), 1);
    cyc;
    bus_if.m0_req = 0; bus_if.m1_req = 0;
    mid;
    chk("ar_final_ack1", 32'(bus_if.m1_ack), 1);
    cyc;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
